// File: rtl/epcs_pkg.sv
// epcs_pkg: EPCS command codes, responder FSM states, address-phase length and command decoder
package epcs_pkg;
  localparam logic [7:0] CMD_READ_STATUS = 8'h05;
  localparam logic [7:0] CMD_READ_ID = 8'hAB;
  localparam logic [7:0] CMD_READ_BYTES = 8'h03;
  localparam int EPCS_ADDR_BYTES = 3;
  localparam logic [1:0] LAST_BYTE = 2'(EPCS_ADDR_BYTES - 1);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_STATUS, S_ID, S_READ, S_IGNORE} state_t;
  function automatic state_t decode_cmd(input logic [7:0] c);
    return c == CMD_READ_STATUS ? S_STATUS : c == CMD_READ_ID ? S_DUMMY : c == CMD_READ_BYTES ? S_ADDR : S_IGNORE;
  endfunction
endpackage

// File: rtl/epcs_pin_sync.sv
// epcs_pin_sync: synchronizes dclk/sce/sdo (in) into clk domain and emits sce_s/sdo_s levels plus rise/fall/sce_fall pulses (out)
module epcs_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic dclk,
  input  logic sce,
  input  logic sdo,
  output logic sce_s,
  output logic sdo_s,
  output logic rise,
  output logic fall,
  output logic sce_fall
);
  logic [SYNC_STAGES-1:0] dclk_q, sce_q, sdo_q;
  logic dclk_p, sce_p;
  always_ff @(posedge clk) begin
    if (rst) begin
      dclk_q <= '1;
      sce_q <= '1;
      sdo_q <= '0;
      dclk_p <= 1'b1;
      sce_p <= 1'b1;
    end else begin
      dclk_q <= {dclk_q[SYNC_STAGES-2:0], dclk};
      sce_q <= {sce_q[SYNC_STAGES-2:0], sce};
      sdo_q <= {sdo_q[SYNC_STAGES-2:0], sdo};
      dclk_p <= dclk_q[SYNC_STAGES-1];
      sce_p <= sce_q[SYNC_STAGES-1];
    end
  end
  assign sce_s = sce_q[SYNC_STAGES-1];
  assign sdo_s = sdo_q[SYNC_STAGES-1];
  assign rise = dclk_q[SYNC_STAGES-1] & ~dclk_p & ~sce_s;
  assign fall = ~dclk_q[SYNC_STAGES-1] & dclk_p & ~sce_s;
  assign sce_fall = ~sce_s & sce_p;
endmodule

// File: rtl/epcs_flash_responder.sv
// epcs_flash_responder: EPCS flash SPI slave (dclk/sce/sdo in, data0/data0_oe out) answering status, silicon id and byte reads via mem_addr/mem_rd/mem_rdata
module epcs_flash_responder #(
  parameter int ADDR_W = 16,
  parameter logic [7:0] SILICON_ID = 8'h14,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              epcs_flash_dclk,
  input  logic              epcs_flash_sce,
  input  logic              epcs_flash_sdo,
  output logic              epcs_flash_data0,
  output logic              epcs_flash_data0_oe,
  input  logic [7:0]        epcs_status,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              cmd_seen
);
  import epcs_pkg::*;
  logic sce_s, sdo_s, rise, fall, sce_fall;
  state_t state, state_n;
  logic [2:0] cnt;
  logic [1:0] bcnt;
  logic [7:0] in_sh, out_sh, hold, in_byte, reload;
  logic [ADDR_W-1:0] a_sh;
  logic rd_v, dst, byte_done, boundary, resp;
  epcs_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_clk),
    .rst(reset_reset),
    .dclk(epcs_flash_dclk),
    .sce(epcs_flash_sce),
    .sdo(epcs_flash_sdo),
    .sce_s(sce_s),
    .sdo_s(sdo_s),
    .rise(rise),
    .fall(fall),
    .sce_fall(sce_fall)
  );
  assign in_byte = {in_sh[6:0], sdo_s};
  assign byte_done = rise & (cnt == 3'd7);
  assign boundary = fall & (cnt == 3'd7);
  assign resp = state inside {S_STATUS, S_ID, S_READ};
  assign reload = state == S_STATUS ? epcs_status : state == S_ID ? SILICON_ID : hold;
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= S_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (sce_fall) state_n = S_CMD;
    else if (sce_s) state_n = S_IDLE;
    else if (byte_done)
      state_n = state == S_CMD ? decode_cmd(in_byte) :
                bcnt != LAST_BYTE ? state :
                state == S_ADDR ? S_READ :
                state == S_DUMMY ? S_ID : state;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      epcs_flash_data0 <= 1'b0;
      epcs_flash_data0_oe <= 1'b0;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      cmd_seen <= 1'b0;
      cnt <= '0;
      bcnt <= '0;
      in_sh <= '0;
      out_sh <= '0;
      hold <= '0;
      a_sh <= '0;
      rd_v <= 1'b0;
      dst <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      cmd_seen <= 1'b0;
      rd_v <= mem_rd;
      if (sce_s || sce_fall) begin
        cnt <= '0;
        bcnt <= '0;
        epcs_flash_data0 <= 1'b0;
        epcs_flash_data0_oe <= 1'b0;
      end else begin
        if (rise) begin
          in_sh <= in_byte;
          cnt <= cnt + 3'd1;
          if (state == S_ADDR) a_sh <= {a_sh[ADDR_W-2:0], sdo_s};
        end
        if (byte_done) begin
          bcnt <= (state == S_ADDR || state == S_DUMMY) && bcnt != LAST_BYTE ? bcnt + 2'd1 : 2'd0;
          cmd_seen <= state == S_CMD;
          if (state == S_CMD && in_byte == CMD_READ_STATUS) out_sh <= epcs_status;
          if (state == S_DUMMY && bcnt == LAST_BYTE) out_sh <= SILICON_ID;
          if (state == S_ADDR && bcnt == LAST_BYTE) begin
            mem_addr <= {a_sh[ADDR_W-2:0], sdo_s};
            mem_rd <= 1'b1;
            dst <= 1'b0;
          end
        end
        if (fall && resp) begin
          epcs_flash_data0 <= out_sh[7];
          epcs_flash_data0_oe <= 1'b1;
          out_sh <= boundary ? reload : {out_sh[6:0], 1'b0};
        end
        if (boundary && state == S_READ) begin
          mem_addr <= mem_addr + ADDR_W'(1);
          mem_rd <= 1'b1;
          dst <= 1'b1;
        end
        // first returned byte goes straight to the shifter and triggers the holding-byte prefetch
        if (rd_v && state == S_READ) begin
          if (dst) hold <= mem_rdata;
          else begin
            out_sh <= mem_rdata;
            mem_addr <= mem_addr + ADDR_W'(1);
            mem_rd <= 1'b1;
            dst <= 1'b1;
          end
        end
      end
    end
  end
endmodule
